multicycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit: the initiator side of the ALU interface. It sequences fetch, decode, execute, memory and writeback over several clocks. Each cycle it drives the ALU operation code and operand selects, plus every datapath enable, from a Moore state machine. It sits beside the shared multi-cycle datapath (single memory, IR, A/B, ALUOut, MDR registers) and consumes the ALU `zero` flag and a memory ready handshake.

---
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control unit for a multi-cycle MIPS datapath (single memory, IR, A/B,
// ALUOut, MDR). A Moore state machine sequences each instruction through
// fetch, decode, execute, memory and writeback.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode, funct     IR[31:26] / IR[5:0], stable from DECODE onward
//   zero              ALU zero flag, only used in BEQ
//   mem_ready         memory access completes this cycle
//   alu_op            ALU operation code
//   alu_src_a/b       ALU operand selects
//   pc_src, pc_en     PC source select and load enable
//   i_or_d            memory address select (PC / ALUOut)
//   mem_read/write    memory requests
//   ir_write          IR load
//   reg_write, reg_dst, mem_to_reg   register file writeback controls
//   illegal           one-cycle pulse on an unsupported instruction
//   retire            one-cycle pulse in each instruction's final state
module multicycle_ctrl #(
    parameter logic [2:0] ALU_AND = 3'b000,
    parameter logic [2:0] ALU_OR  = 3'b001,
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b110,
    parameter logic [2:0] ALU_SLT = 3'b111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       retire
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR,
        S_R_EX, S_R_WB, S_I_EX, S_I_WB, S_BEQ, S_JUMP
    } state_t;

    state_t state_reg, state_next;

    logic funct_ok;
    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_next = funct_ok ? S_R_EX : S_FETCH;
                    OP_LW, OP_SW:    state_next = S_ADDR;
                    OP_ADDI, OP_SLTI: state_next = S_I_EX;
                    OP_BEQ:          state_next = S_BEQ;
                    OP_J:            state_next = S_JUMP;
                    default:         state_next = S_FETCH;
                endcase
            end
            // Only lw and sw can reach ADDR, so one compare is enough.
            S_ADDR:   state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_next = mem_ready ? S_LW_WB : S_MEM_RD;
            S_MEM_WR: state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:   state_next = S_R_WB;
            S_I_EX:   state_next = S_I_WB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output decode from the state register (plus mem_ready/zero for the
    // handshake-qualified strobes and opcode/funct for the ALU op).
    logic [2:0] alu_op_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] pc_src_c;
    logic       pc_en_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
    logic       reg_write_c, reg_dst_c, mem_to_reg_c, illegal_c, retire_c;

    always_comb begin
        alu_op_c     = 3'b000;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        pc_src_c     = 2'b00;
        pc_en_c      = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        illegal_c    = 1'b0;
        retire_c     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                alu_op_c    = ALU_ADD;
                // PC+4 and IR load only commit once memory delivers.
                ir_write_c  = mem_ready;
                pc_en_c     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_op_c    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                               illegal_c = !funct_ok;
                    OP_LW, OP_SW, OP_ADDI, OP_SLTI,
                    OP_BEQ, OP_J:                           illegal_c = 1'b0;
                    default:                                illegal_c = 1'b1;
                endcase
            end
            S_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
            end
            S_LW_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire_c     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                retire_c    = mem_ready;
            end
            S_R_EX: begin
                alu_src_a_c = 1'b1;
                case (funct)
                    FN_SUB:  alu_op_c = ALU_SUB;
                    FN_AND:  alu_op_c = ALU_AND;
                    FN_OR:   alu_op_c = ALU_OR;
                    FN_SLT:  alu_op_c = ALU_SLT;
                    default: alu_op_c = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire_c    = 1'b1;
            end
            S_I_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = 2'b01;
                pc_en_c     = zero;
                retire_c    = 1'b1;
            end
            S_JUMP: begin
                pc_src_c = 2'b10;
                pc_en_c  = 1'b1;
                retire_c = 1'b1;
            end
            default: begin
                alu_op_c = 3'b000;
            end
        endcase
    end

    // Outputs are held at zero for as long as reset is asserted, so an
    // aborted instruction cannot leak a write while rst_n is low.
    assign alu_op     = rst_n ? alu_op_c     : 3'b000;
    assign alu_src_a  = rst_n & alu_src_a_c;
    assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
    assign pc_src     = rst_n ? pc_src_c     : 2'b00;
    assign pc_en      = rst_n & pc_en_c;
    assign i_or_d     = rst_n & i_or_d_c;
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign ir_write   = rst_n & ir_write_c;
    assign reg_write  = rst_n & reg_write_c;
    assign reg_dst    = rst_n & reg_dst_c;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign illegal    = rst_n & illegal_c;
    assign retire     = rst_n & retire_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: cycle-by-cycle directed trace table with
// hand-computed expected control vectors, plus a hand-written sequence for
// asynchronous reset in the middle of a store.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal, retire;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all outputs:
    // {alu_op, src_a, src_b, pc_src, pc_en, i_or_d, mem_read, mem_write,
    //  ir_write, reg_write, reg_dst, mem_to_reg, illegal, retire}
    logic [17:0] act;
    assign act = {alu_op, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, mem_read,
                  mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal, retire};

    typedef struct {
        string       name;
        bit          rst;
        bit [5:0]    op;
        bit [5:0]    fn;
        bit          z;
        bit          rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    function automatic logic [17:0] mk(input logic [2:0] op, input logic a,
            input logic [1:0] b, input logic [1:0] pcs, input logic pce,
            input logic iod, input logic mr, input logic mw, input logic irw,
            input logic rw, input logic rd, input logic m2r, input logic ill,
            input logic ret);
        return {op, a, b, pcs, pce, iod, mr, mw, irw, rw, rd, m2r, ill, ret};
    endfunction

    task automatic add(input string nm, input bit r, input bit [5:0] op,
                       input bit [5:0] fn, input bit z, input bit rdy,
                       input logic [17:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got === want) begin
            passed++;
            $display("check %-14s got %b", nm, got);
        end else begin
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
    endtask

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic [17:0] e_f0, e_f1, e_dec, e_ill, e_addr, e_mrd, e_lwb, e_mw0, e_mw1;
    logic [17:0] e_rwb, e_iwb, e_beq1, e_beq0, e_jmp, e_zero;

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;

        e_zero = 18'd0;
        e_f0   = mk(3'b010, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_f1   = mk(3'b010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        e_dec  = mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_ill  = mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e_addr = mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_mrd  = mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        e_lwb  = mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        e_mw0  = mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        e_mw1  = mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        e_rwb  = mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        e_iwb  = mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        e_beq1 = mk(3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_beq0 = mk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_jmp  = mk(3'b000, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset holds every output low, even with mem_ready high
        add("reset0",    0, RT, F_ADD, 1, 1, e_zero);
        add("reset1",    0, RT, F_ADD, 0, 1, e_zero);
        // R-type sub with two fetch stalls
        add("sub_f_st1", 1, RT, F_SUB, 0, 0, e_f0);
        add("sub_f_st2", 1, RT, F_SUB, 1, 0, e_f0);
        add("sub_fetch", 1, RT, F_SUB, 0, 1, e_f1);
        add("sub_dec",   1, RT, F_SUB, 1, 1, e_dec);
        add("sub_rex",   1, RT, F_SUB, 1, 0, mk(3'b110, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sub_rwb",   1, RT, F_SUB, 0, 1, e_rwb);
        // lw, mem_ready high throughout
        add("lw_fetch",  1, LW, F_ADD, 0, 1, e_f1);
        add("lw_dec",    1, LW, F_ADD, 0, 1, e_dec);
        add("lw_addr",   1, LW, F_ADD, 0, 1, e_addr);
        add("lw_memrd",  1, LW, F_ADD, 0, 1, e_mrd);
        add("lw_wb",     1, LW, F_ADD, 0, 1, e_lwb);
        // sw with one store stall
        add("sw_fetch",  1, SW, F_ADD, 0, 1, e_f1);
        add("sw_dec",    1, SW, F_ADD, 0, 1, e_dec);
        add("sw_addr",   1, SW, F_ADD, 0, 1, e_addr);
        add("sw_memwr0", 1, SW, F_ADD, 0, 0, e_mw0);
        add("sw_memwr1", 1, SW, F_ADD, 0, 1, e_mw1);
        // beq taken / not taken
        add("beq1_fetch", 1, BEQ, F_ADD, 0, 1, e_f1);
        add("beq1_dec",   1, BEQ, F_ADD, 0, 1, e_dec);
        add("beq1_ex",    1, BEQ, F_ADD, 1, 0, e_beq1);
        add("beq0_fetch", 1, BEQ, F_ADD, 1, 1, e_f1);
        add("beq0_dec",   1, BEQ, F_ADD, 1, 1, e_dec);
        add("beq0_ex",    1, BEQ, F_ADD, 0, 1, e_beq0);
        // slti and addi
        add("slti_fetch", 1, SLTI, F_ADD, 0, 1, e_f1);
        add("slti_dec",   1, SLTI, F_ADD, 0, 1, e_dec);
        add("slti_ex",    1, SLTI, F_ADD, 1, 1, mk(3'b111, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("slti_wb",    1, SLTI, F_ADD, 0, 1, e_iwb);
        add("addi_fetch", 1, ADDI, F_SLT, 0, 1, e_f1);
        add("addi_dec",   1, ADDI, F_SLT, 0, 1, e_dec);
        add("addi_ex",    1, ADDI, F_SLT, 0, 1, mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("addi_wb",    1, ADDI, F_SLT, 0, 1, e_iwb);
        // j
        add("j_fetch",    1, JMP, F_ADD, 0, 1, e_f1);
        add("j_dec",      1, JMP, F_ADD, 0, 1, e_dec);
        add("j_ex",       1, JMP, F_ADD, 0, 0, e_jmp);
        // illegal opcode and illegal R-type funct
        add("ill_fetch",  1, BAD, F_ADD, 0, 1, e_f1);
        add("ill_dec",    1, BAD, F_ADD, 0, 1, e_ill);
        add("illr_fetch", 1, RT, 6'b000000, 0, 1, e_f1);
        add("illr_dec",   1, RT, 6'b000000, 0, 1, e_ill);
        add("after_ill",  1, RT, F_AND, 0, 0, e_f0);
        // and / or / slt R-types
        add("and_fetch",  1, RT, F_AND, 0, 1, e_f1);
        add("and_dec",    1, RT, F_AND, 0, 1, e_dec);
        add("and_rex",    1, RT, F_AND, 0, 1, mk(3'b000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("and_rwb",    1, RT, F_AND, 0, 1, e_rwb);
        add("or_fetch",   1, RT, F_OR, 0, 1, e_f1);
        add("or_dec",     1, RT, F_OR, 0, 1, e_dec);
        add("or_rex",     1, RT, F_OR, 0, 1, mk(3'b001, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("or_rwb",     1, RT, F_OR, 0, 1, e_rwb);
        add("slt_fetch",  1, RT, F_SLT, 0, 1, e_f1);
        add("slt_dec",    1, RT, F_SLT, 0, 1, e_dec);
        add("slt_rex",    1, RT, F_SLT, 0, 1, mk(3'b111, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("slt_rwb",    1, RT, F_SLT, 0, 1, e_rwb);

        // Inputs change 1 time unit after the rising edge; outputs are
        // compared on the falling edge.
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst;
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            chk(vecs[i].name, act, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Hand-written: reset asserted mid MEM_WR aborts the store at once.
        opcode = SW; funct = F_ADD; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); chk("rst_sw_fetch", act, e_f1);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_sw_dec", act, e_dec);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_sw_addr", act, e_addr);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk); chk("rst_sw_memwr", act, e_mw0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_mw", {17'd0, mem_write}, 18'd0);
        chk("rst_async_all", act, e_zero);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk); chk("rst_held", act, e_zero);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); chk("rst_rel_fetch", act, e_f1);
        @(posedge clk); #1;
        // The aborted store must not resume: a fresh decode follows.
        @(negedge clk); chk("rst_rel_dec", act, e_dec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
